// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save adder slice. A build-wide default
// width and the registered output bundle layout are defined here.
package csa_pkg;

    localparam int CSA_DEFAULT_BIT_LEN = 19;

    // Registered output bundle at the default width. The top declares the
    // same layout sized by its own BIT_LEN parameter.
    typedef struct packed {
        logic [CSA_DEFAULT_BIT_LEN-1:0] s;
        logic [CSA_DEFAULT_BIT_LEN-1:0] cout;
        logic                           valid;
    } csa_out_t;

endpackage

// File: rtl/full_adder.sv
// One bit column of the 3:2 compressor: sum and majority carry.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/carry_save_adder.sv
// 3:2 carry-save adder with an optional one-stage output register.
// Define CSA_FINAL_ADD_EN to add a carry-propagate adder that resolves
// S + (Cout << 1) and registers the result on Sum_q.
module carry_save_adder
    import csa_pkg::*;
#(
    parameter int BIT_LEN = CSA_DEFAULT_BIT_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [BIT_LEN-1:0] A,
    input  logic [BIT_LEN-1:0] B,
    input  logic [BIT_LEN-1:0] Cin,
    output logic [BIT_LEN-1:0] S,
    output logic [BIT_LEN-1:0] Cout,
    output logic [BIT_LEN-1:0] S_q,
    output logic [BIT_LEN-1:0] Cout_q,
    output logic               out_valid
`ifdef CSA_FINAL_ADD_EN
    ,
    output logic [BIT_LEN+1:0] Sum_q
`endif
);

    // Same layout as csa_pkg::csa_out_t, sized by this instance's width.
    typedef struct packed {
        logic [BIT_LEN-1:0] s;
        logic [BIT_LEN-1:0] cout;
        logic               valid;
    } out_bundle_t;

    out_bundle_t out_d, out_q;

    // One full adder per bit column; Cout stays unshifted (bit i weighs 2^(i+1)).
    for (genvar i = 0; i < BIT_LEN; i++) begin : g_col
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (Cin[i]),
            .s    (S[i]),
            .cout (Cout[i])
        );
    end

    // Next state: capture the vectors only when qualified, valid always follows.
    always_comb begin
        out_d       = out_q;
        out_d.valid = in_valid;
        if (in_valid) begin
            out_d.s    = S;
            out_d.cout = Cout;
        end
    end

    // Output register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign S_q       = out_q.s;
    assign Cout_q    = out_q.cout;
    assign out_valid = out_q.valid;

`ifdef CSA_FINAL_ADD_EN
    logic [BIT_LEN+1:0] sum_d, sum_q;

    // Resolve at BIT_LEN+2 bits so the top carry can never be dropped.
    always_comb begin
        sum_d = sum_q;
        if (in_valid) sum_d = {2'b00, S} + {1'b0, Cout, 1'b0};
    end

    // Resolved sum is registered alongside S_q/Cout_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign Sum_q = sum_q;
`endif

endmodule

// File: tb/tb_carry_save_adder.sv
// Self-checking bench for carry_save_adder: directed vectors, hold/valid,
// asynchronous reset, then randomized inputs against an arithmetic model.
module tb_carry_save_adder;

    localparam int W = 19;

    logic         clk, rst, in_valid;
    logic [W-1:0] A, B, Cin, S, Cout, S_q, Cout_q;
    logic         out_valid;
`ifdef CSA_FINAL_ADD_EN
    logic [W+1:0] Sum_q;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state for the registered stage.
    logic [W-1:0] exp_sq, exp_cq;
    logic         exp_ov;
    logic [63:0]  exp_sum;

    carry_save_adder #(.BIT_LEN(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .S_q       (S_q),
        .Cout_q    (Cout_q),
        .out_valid (out_valid)
`ifdef CSA_FINAL_ADD_EN
        ,
        .Sum_q     (Sum_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column-wise count of ones: the count's low bit is the sum bit, the
    // count halved is the carry bit. Returns {cout, s}.
    function automatic logic [2*W-1:0] csa_ref(input logic [W-1:0] a, b, c);
        logic [W-1:0] s, co;
        int n;
        for (int i = 0; i < W; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            s[i]  = (n % 2) == 1;
            co[i] = (n / 2) == 1;
        end
        return {co, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        logic [2*W-1:0] r;
        r = csa_ref(A, B, Cin);
        chk("S", 64'(S), 64'(r[W-1:0]));
        chk("Cout", 64'(Cout), 64'(r[2*W-1:W]));
        chk("invariant", 64'(S) + 2 * 64'(Cout), 64'(A) + 64'(B) + 64'(Cin));
    endtask

    task automatic check_regs();
        chk("S_q", 64'(S_q), 64'(exp_sq));
        chk("Cout_q", 64'(Cout_q), 64'(exp_cq));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
`ifdef CSA_FINAL_ADD_EN
        chk("Sum_q", 64'(Sum_q), exp_sum);
`endif
    endtask

    task automatic model_reset();
        exp_sq  = '0;
        exp_cq  = '0;
        exp_ov  = 1'b0;
        exp_sum = '0;
    endtask

    // Drive at the falling edge and check the combinational outputs.
    task automatic drive(input logic [W-1:0] a, b, c, input logic v);
        A = a; B = b; Cin = c; in_valid = v;
        #1;
        check_comb();
    endtask

    // One rising edge: update the model, check registers, return to the falling edge.
    task automatic step();
        logic [2*W-1:0] r;
        @(posedge clk);
        if (!rst) begin
            exp_ov = in_valid;
            if (in_valid) begin
                r       = csa_ref(A, B, Cin);
                exp_sq  = r[W-1:0];
                exp_cq  = r[2*W-1:W];
                exp_sum = 64'(A) + 64'(B) + 64'(Cin);
            end
        end
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = '0;
        model_reset();
        #2;
        check_regs();
        @(negedge clk);
        rst = 1'b0;

        // Reference vector
        drive(19'h457ED, 19'h5F78C, 19'h5E9F9, 1'b1);
        chk("vec1_S", 64'(S), 64'h44998);
        chk("vec1_Cout", 64'(Cout), 64'h5F7ED);
        step();
`ifdef CSA_FINAL_ADD_EN
        chk("vec1_Sum_q", 64'(Sum_q), 64'h103972);
`endif

        // All zero
        drive('0, '0, '0, 1'b1);
        step();
        chk("zero_S_q", 64'(S_q), 64'h0);
        chk("zero_valid", 64'(out_valid), 64'h1);

        // All ones: top carry must survive
        drive(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b1);
        chk("ones_S", 64'(S), 64'h7FFFF);
        chk("ones_Cout", 64'(Cout), 64'h7FFFF);
        step();
`ifdef CSA_FINAL_ADD_EN
        chk("ones_Sum_q", 64'(Sum_q), 64'h17FFFD);
`endif

        // Carry weight
        drive(19'h1, 19'h1, 19'h0, 1'b1);
        chk("cw_S", 64'(S), 64'h0);
        chk("cw_Cout", 64'(Cout), 64'h1);
        step();
`ifdef CSA_FINAL_ADD_EN
        chk("cw_Sum_q", 64'(Sum_q), 64'h2);
`endif
        drive(19'h1, 19'h0, 19'h0, 1'b1);
        chk("a1_S", 64'(S), 64'h1);
        chk("a1_Cout", 64'(Cout), 64'h0);
        step();

        // Hold: registers keep vector 1 while in_valid is low
        drive(19'h457ED, 19'h5F78C, 19'h5E9F9, 1'b1);
        step();
        drive(W'($urandom), W'($urandom), W'($urandom), 1'b0);
        step();
        chk("hold_S_q", 64'(S_q), 64'h44998);
        chk("hold_Cout_q", 64'(Cout_q), 64'h5F7ED);
        chk("hold_valid", 64'(out_valid), 64'h0);

        // Asynchronous reset between edges
        drive(19'h12345, 19'h6789A, 19'h0BCDE, 1'b1);
        step();
        drive(19'h7A5A5, 19'h05A5A, 19'h3C3C3, 1'b1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_regs();
        check_comb();
        // Reset wins over in_valid across an edge
        step();
        rst = 1'b0;
        step();

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            drive(W'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
